ahb_resp_mux: RTL and testbench

Parametrised AHB-Lite slave-to-master response multiplexer with a registered data-phase select. It sits between the address decoder and slaves on one side and the single master on the other. It captures the decoder's one-hot HSEL at each accepted address phase and routes the matching slave's HRDATA/HREADYOUT/HRESP back during the following data phase. It also provides an optional built-in default slave that answers unmapped transfers with the two-cycle AHB ERROR response.

---
 rtl/ahb_resp_mux_pkg.sv | 28 ++
 rtl/ahb_default_slave.sv | 28 ++
 rtl/ahb_resp_mux.sv | 106 ++++++++++
 tb/tb_ahb_resp_mux.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/ahb_resp_mux_pkg.sv
// Shared AHB-Lite types for the response multiplexer and its default slave.
// Pure definitions, no logic state.
package ahb_resp_mux_pkg;

  typedef enum logic {
    OKAY  = 1'b0,
    ERROR = 1'b1
  } Response_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } HTrans_t;

  typedef enum logic [1:0] {
    NO_XFER,
    SLAVE,
    ERR1,
    ERR2
  } dp_state_t;

  function automatic logic is_active(input logic [1:0] htrans);
    return (htrans == NONSEQ) || (htrans == SEQ);
  endfunction

endpackage

// File: rtl/ahb_default_slave.sv
// Default slave: two-cycle AHB ERROR (one wait with ERROR, then done with ERROR).
// start pulses on the accepting edge; the sequence cannot be stalled or cancelled.
module ahb_default_slave (
  input  logic HCLK,
  input  logic HRESET,
  input  logic start,
  output logic hready,
  output logic hresp
);
  import ahb_resp_mux_pkg::*;

  logic err1_q;
  logic err2_q;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      err1_q <= 1'b0;
      err2_q <= 1'b0;
    end else begin
      err1_q <= start;
      err2_q <= err1_q;
    end
  end

  assign hready = ~err1_q;
  assign hresp  = (err1_q || err2_q) ? ERROR : OKAY;

endmodule

// File: rtl/ahb_resp_mux.sv
// AHB-Lite slave-to-master response mux; select registered at the address phase, data path combinational.
// Optional default slave for unmapped/multi-hot transfers under AHB_MUX_DEFAULT_SLAVE_EN.
module ahb_resp_mux #(
  parameter int NUM_SLAVES = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                             HCLK,
  input  logic                             HRESET,
  input  logic [NUM_SLAVES-1:0]            HSEL,
  input  logic [1:0]                       HTRANS,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] HRDATA_S,
  input  logic [NUM_SLAVES-1:0]            HREADYOUT_S,
  input  logic [NUM_SLAVES-1:0]            HRESP_S,
  output logic [DATA_WIDTH-1:0]            HRDATA,
  output logic                             HREADY,
  output logic                             HRESP
);
  import ahb_resp_mux_pkg::*;

  localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  dp_state_t        state_q, state_d;
  logic [IDX_W-1:0] sel_q, sel_d;
  logic [IDX_W-1:0] hit_idx;
  logic             sel_one_hot;
  logic             ds_start;

  // Multi-hot is treated as unmapped so slave data is never ORed together.
  assign sel_one_hot = (HSEL != '0) && ((HSEL & (HSEL - NUM_SLAVES'(1))) == '0);

  always_comb begin
    hit_idx = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (HSEL[i]) hit_idx = IDX_W'(i);
    end
  end

`ifdef AHB_MUX_DEFAULT_SLAVE_EN
  logic ds_hready;
  logic ds_hresp;

  ahb_default_slave u_default_slave (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .start  (ds_start),
    .hready (ds_hready),
    .hresp  (ds_hresp)
  );
`endif

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q <= NO_XFER;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    ds_start = 1'b0;
    HREADY   = 1'b1;
    HRESP    = OKAY;
    HRDATA   = '0;

    case (state_q)
      SLAVE: begin
        HRDATA = HRDATA_S[sel_q*DATA_WIDTH +: DATA_WIDTH];
        HREADY = HREADYOUT_S[sel_q];
        HRESP  = HRESP_S[sel_q];
      end
`ifdef AHB_MUX_DEFAULT_SLAVE_EN
      ERR1, ERR2: begin
        HREADY = ds_hready;
        HRESP  = ds_hresp;
      end
`endif
      default: ;
    endcase

`ifdef AHB_MUX_DEFAULT_SLAVE_EN
    if (state_q == ERR1) begin
      state_d = ERR2;
    end else
`endif
    if (HREADY) begin
      if (!is_active(HTRANS)) begin
        state_d = NO_XFER;
      end else if (sel_one_hot) begin
        state_d = SLAVE;
        sel_d   = hit_idx;
      end else begin
`ifdef AHB_MUX_DEFAULT_SLAVE_EN
        state_d  = ERR1;
        ds_start = 1'b1;
`else
        state_d  = NO_XFER;
`endif
      end
    end
  end

endmodule

// File: tb/tb_ahb_resp_mux.sv
// Scoreboard bench for ahb_resp_mux: directed test-plan cases followed by random traffic,
// expectations from a transfer-level model of the data phase.
module tb_ahb_resp_mux;
  localparam int N = 4;
  localparam int W = 32;

  logic             HCLK = 1'b0;
  logic             HRESET;
  logic [N-1:0]     HSEL;
  logic [1:0]       HTRANS;
  logic [N*W-1:0]   HRDATA_S;
  logic [N-1:0]     HREADYOUT_S;
  logic [N-1:0]     HRESP_S;
  logic [W-1:0]     HRDATA;
  logic             HREADY;
  logic             HRESP;

  ahb_resp_mux #(.NUM_SLAVES(N), .DATA_WIDTH(W)) dut (
    .HCLK        (HCLK),
    .HRESET      (HRESET),
    .HSEL        (HSEL),
    .HTRANS      (HTRANS),
    .HRDATA_S    (HRDATA_S),
    .HREADYOUT_S (HREADYOUT_S),
    .HRESP_S     (HRESP_S),
    .HRDATA      (HRDATA),
    .HREADY      (HREADY),
    .HRESP       (HRESP)
  );

  always #5 HCLK = ~HCLK;

  typedef struct packed {
    logic         rdy;
    logic         resp;
    logic [W-1:0] dat;
  } exp_t;

  exp_t q[$];
  int   compared   = 0;
  int   mismatched = 0;

  // Model: what the current data phase is serving. kind 0 = nothing, 1 = slave, 2 = default error.
  int cur_kind = 0;
  int cur_slave = 0;
  int err_left = 0;

  function automatic exp_t predict();
    exp_t e;
    e = '{rdy: 1'b1, resp: 1'b0, dat: '0};
    if (HRESET) return e;
    if (cur_kind == 1) begin
      e.rdy  = HREADYOUT_S[cur_slave];
      e.resp = HRESP_S[cur_slave];
      e.dat  = HRDATA_S[cur_slave*W +: W];
    end else if (cur_kind == 2) begin
      e.rdy  = (err_left == 1);
      e.resp = 1'b1;
    end
    return e;
  endfunction

  task automatic advance(input logic rdy);
    int ones;
    if (cur_kind == 2 && err_left == 2) begin
      err_left = 1;
      return;
    end
    if (!rdy) return;
    ones = $countones(HSEL);
    if (HTRANS != 2'b10 && HTRANS != 2'b11) begin
      cur_kind = 0;
    end else if (ones == 1) begin
      cur_kind = 1;
      for (int i = 0; i < N; i++) if (HSEL[i]) cur_slave = i;
    end else begin
`ifdef AHB_MUX_DEFAULT_SLAVE_EN
      cur_kind = 2;
      err_left = 2;
`else
      cur_kind = 0;
`endif
    end
  endtask

  // Drive one cycle just after a rising edge; expectation is queued for the falling-edge monitor.
  task automatic step(input logic rst, input logic [N-1:0] sel, input logic [1:0] tr,
                      input logic [N*W-1:0] d, input logic [N-1:0] ro, input logic [N-1:0] rs);
    exp_t e;
    HRESET = rst;
    HSEL = sel;
    HTRANS = tr;
    HRDATA_S = d;
    HREADYOUT_S = ro;
    HRESP_S = rs;
    if (rst) begin
      cur_kind = 0;
      err_left = 0;
    end
    e = predict();
    q.push_back(e);
    @(posedge HCLK);
    if (!HRESET) advance(e.rdy);
    #1;
  endtask

  function automatic logic [N*W-1:0] rand_data();
    logic [N*W-1:0] d;
    for (int i = 0; i < N; i++) d[i*W +: W] = $urandom;
    return d;
  endfunction

  function automatic logic [N-1:0] rand_ready();
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = ($urandom_range(0, 3) != 0);
    return r;
  endfunction

  always @(negedge HCLK) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      compared++;
      if ({HREADY, HRESP, HRDATA} !== {e.rdy, e.resp, e.dat}) begin
        mismatched++;
        $display("FAIL resp_cycle%0d: got hready=%b hresp=%b hrdata=%h, want hready=%b hresp=%b hrdata=%h",
                 compared, HREADY, HRESP, HRDATA, e.rdy, e.resp, e.dat);
      end
    end
  end

  initial begin
    logic [N*W-1:0] d;
    logic [N-1:0]   sel;
    HRESET = 1'b1;
    HSEL = '0;
    HTRANS = 2'b00;
    HRDATA_S = '0;
    HREADYOUT_S = '1;
    HRESP_S = '0;
    @(posedge HCLK);
    #1;

    // Reset with garbage on the slave side and an active request
    for (int i = 0; i < 3; i++) step(1'b1, 4'b0010, 2'b10, rand_data(), $urandom, $urandom);

    // Routing to slave 2 while others drive all-ones
    d = {N*W{1'b1}};
    d[2*W +: W] = 32'hA5A5_0002;
    step(1'b0, 4'b0100, 2'b10, d, 4'b1111, 4'b0000);
    step(1'b0, 4'b0000, 2'b00, d, 4'b1011, 4'b0000);
    step(1'b0, 4'b0000, 2'b00, d, 4'b1111, 4'b0000);

    // Slave 1 inserts three wait states while the decoder already selects slave 0
    step(1'b0, 4'b0010, 2'b10, rand_data(), 4'b1111, 4'b0000);
    for (int i = 0; i < 3; i++) step(1'b0, 4'b0001, 2'b11, rand_data(), 4'b1101, 4'b0000);
    step(1'b0, 4'b0001, 2'b11, rand_data(), 4'b1111, 4'b0000);
    step(1'b0, 4'b0000, 2'b00, rand_data(), 4'b1111, 4'b0000);
    step(1'b0, 4'b0000, 2'b00, rand_data(), 4'b1111, 4'b0000);

    // Unmapped, then multi-hot; master drops to IDLE during the error wait
    step(1'b0, 4'b0000, 2'b10, rand_data(), 4'b1111, 4'b0000);
    step(1'b0, 4'b0000, 2'b00, rand_data(), 4'b1111, 4'b0000);
    step(1'b0, 4'b0000, 2'b00, rand_data(), 4'b1111, 4'b0000);
    step(1'b0, 4'b0011, 2'b10, rand_data(), 4'b1111, 4'b0000);
    step(1'b0, 4'b0011, 2'b00, rand_data(), 4'b1111, 4'b0000);
    step(1'b0, 4'b0000, 2'b00, rand_data(), 4'b1111, 4'b0000);
    step(1'b0, 4'b0000, 2'b00, rand_data(), 4'b1111, 4'b0000);

    // IDLE and BUSY to slave 3 give no transfer
    step(1'b0, 4'b1000, 2'b00, rand_data(), 4'b0000, 4'b1111);
    step(1'b0, 4'b1000, 2'b01, rand_data(), 4'b0000, 4'b1111);
    step(1'b0, 4'b0000, 2'b00, rand_data(), 4'b0000, 4'b1111);

    // Reset lands in the first error cycle
    step(1'b0, 4'b0000, 2'b10, rand_data(), 4'b1111, 4'b0000);
    step(1'b1, 4'b0000, 2'b00, rand_data(), 4'b1111, 4'b0000);
    step(1'b0, 4'b0000, 2'b00, rand_data(), 4'b1111, 4'b0000);

    // Random traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      case ($urandom_range(0, 9))
        6:       sel = '0;
        7, 8, 9: sel = N'($urandom);
        default: sel = N'(1) << $urandom_range(0, N - 1);
      endcase
      step(($urandom_range(0, 199) == 0), sel, 2'($urandom_range(0, 3)), rand_data(),
           rand_ready(), ($urandom_range(0, 9) == 0) ? N'($urandom) : '0);
    end

    @(negedge HCLK);
    #1;
    if (q.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
